// File: rtl/seq_divider_8b.sv
// seq_divider_8b
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per cycle, producing an 8-bit quotient and a 4-bit remainder. It is the
// companion of the 4x4 array multiplier: a product can be split back into
// its operands. Valid/ready handshakes on both the request and result sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid (x, y sampled only in the accept cycle)
//   in_ready   divider idle and able to accept a request
//   x [7:0]    dividend
//   y [3:0]    divisor
//   out_valid  result valid (registered, only in DONE)
//   out_ready  consumer accepts the result
//   q [7:0]    quotient (8'hFF when the divisor was zero)
//   r [3:0]    remainder (0 when the divisor was zero)
//   dz         the divisor of this result was zero
//
// Fixed latency: accept in cycle T, out_valid from cycle T+9, for every
// operand pair including a zero divisor.
module seq_divider_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [3:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;        // iteration counter, 0..7
  logic [4:0] rem_q;        // partial remainder R
  logic [7:0] quo_q;        // dividend shifting out / quotient shifting in
  logic [3:0] div_q;        // divisor captured at accept
  logic       out_valid_q;
  logic [7:0] q_q;
  logic [3:0] r_q;
  logic       dz_q;

  // One restoring iteration. The shifted remainder is formed at 6 bits so
  // that the whole of R takes part in the compare: with a non-zero divisor
  // R stays below 16 and the top bits are zero, with a zero divisor R may
  // grow but the result is overridden in DONE anyway.
  logic [5:0] shift_d;
  logic       no_borrow_d;
  logic [4:0] rem_d;
  logic [7:0] quo_d;

  always_comb begin
    shift_d     = {rem_q, quo_q[7]};
    no_borrow_d = (shift_d >= {2'b00, div_q});
    rem_d       = no_borrow_d ? (shift_d[4:0] - {1'b0, div_q}) : shift_d[4:0];
    quo_d       = {quo_q[6:0], no_borrow_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rem_q       <= 5'd0;
      quo_q       <= 8'd0;
      div_q       <= 4'd0;
      out_valid_q <= 1'b0;
      q_q         <= 8'd0;
      r_q         <= 4'd0;
      dz_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            quo_q   <= x;
            rem_q   <= 5'd0;
            div_q   <= y;
            cnt_q   <= 4'd0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            // Result registers are loaded from the final iteration directly,
            // so they are stable for the whole DONE phase.
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            dz_q        <= (div_q == 4'd0);
            q_q         <= (div_q == 4'd0) ? 8'hFF : quo_d;
            r_q         <= (div_q == 4'd0) ? 4'h0  : rem_d[3:0];
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready must be low while rst is asserted, so it is gated by rst
  // directly rather than taken from a register.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dz        = dz_q;

endmodule
